// File: rtl/iir_pkg.sv
// Types and sizing shared by the IIR chain: my_iir, data_maker, data_sink and the output buffer.
package iir_pkg;

    localparam int NB        = 12;
    localparam int OUT_DEPTH = 8;

    typedef logic [NB-1:0] sample_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: storage, wrapping pointers and an explicit occupancy counter.
// The head word is visible combinationally from the registered read pointer.
module sync_fifo_fwft #(
    parameter int W     = 12,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          vout_o,
    output logic [AW:0]   level_o,
    output logic          full_o
);

    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push_en;
    logic          pop_en;

    assign push_en = push_i && !clr_i;
    assign pop_en  = pop_i  && !clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_en, pop_en})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately unreset; the empty case is masked on the output instead.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= din_i;
    end

    assign vout_o  = (level_q != '0);
    assign dout_o  = vout_o ? mem_q[rd_ptr_q] : '0;
    assign level_o = level_q;
    assign full_o  = (level_q == LEVEL_FULL);

endmodule

// File: rtl/iir_out_buffer.sv
// Elastic output stage behind my_iir: valid/ready handshake, overflow drop with sticky OVF,
// and a synchronous clear that takes priority over push and pop.
module iir_out_buffer #(
    parameter int NB    = iir_pkg::NB,
    parameter int DEPTH = iir_pkg::OUT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic [NB-1:0] DIN,
    input  logic          VIN,
    input  logic          CLR,
    input  logic          RDY,
    output logic [NB-1:0] DOUT,
    output logic          VOUT,
    output logic [AW:0]   LEVEL,
    output logic          FULL,
    output logic          OVF
);

    logic ovf_q, ovf_d;
    logic pop_w;
    logic push_w;
    logic drop_w;

    // A pop frees a slot in the same edge, so a full FIFO can still accept while draining.
    assign pop_w  = VOUT && RDY && !CLR;
    assign push_w = VIN && (!FULL || pop_w) && !CLR;
    assign drop_w = VIN && FULL && !pop_w;

    always_comb begin
        ovf_d = ovf_q;
        if (CLR)         ovf_d = 1'b0;
        else if (drop_w) ovf_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign OVF = ovf_q;

    sync_fifo_fwft #(
        .W     (NB),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_n_i (RST_n),
        .clr_i   (CLR),
        .push_i  (push_w),
        .pop_i   (pop_w),
        .din_i   (DIN),
        .dout_o  (DOUT),
        .vout_o  (VOUT),
        .level_o (LEVEL),
        .full_o  (FULL)
    );

endmodule

// File: tb/tb_iir_out_buffer.sv
// Directed and scoreboard checks of iir_out_buffer: pass-through, stall, overflow, full push+pop,
// clear, asynchronous reset and pointer wrap under random traffic.
module tb_iir_out_buffer;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic [11:0] DIN;
    logic        VIN;
    logic        CLR;
    logic        RDY;
    logic [11:0] DOUT;
    logic        VOUT;
    logic [3:0]  LEVEL;
    logic        FULL;
    logic        OVF;

    int n_vec = 0;
    int n_err = 0;

    iir_out_buffer dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .DIN   (DIN),
        .VIN   (VIN),
        .CLR   (CLR),
        .RDY   (RDY),
        .DOUT  (DOUT),
        .VOUT  (VOUT),
        .LEVEL (LEVEL),
        .FULL  (FULL),
        .OVF   (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Fill from empty with the consumer stalled; head must stay on the first word.
    task automatic fill(input string tag, input logic [11:0] vals[$]);
        RDY = 1'b0;
        foreach (vals[i]) begin
            VIN = 1'b1;
            DIN = vals[i];
            step();
            check({tag, "_head"}, DOUT, vals[0]);
            check({tag, "_level"}, LEVEL, i + 1);
        end
        VIN = 1'b0;
    endtask

    task automatic drain(input string tag, input logic [11:0] vals[$]);
        foreach (vals[i]) begin
            check({tag, "_dout"}, DOUT, vals[i]);
            check({tag, "_vout"}, VOUT, 1);
            RDY = 1'b1;
            step();
        end
        RDY = 1'b0;
        check({tag, "_empty_vout"}, VOUT, 0);
        check({tag, "_empty_level"}, LEVEL, 0);
        check({tag, "_empty_dout"}, DOUT, 0);
    endtask

    initial begin
        logic [11:0] vals[$];
        logic [11:0] exp_q[$];
        logic [11:0] mq[$];
        logic        ovf_m;
        logic        m_pop, m_push, m_full;
        logic        r_vin, r_rdy;
        logic [11:0] r_din;
        int          pushes;

        RST_n = 1'b0;
        DIN   = '0;
        VIN   = 1'b0;
        CLR   = 1'b0;
        RDY   = 1'b0;
        @(negedge CLK);
        check("rst_dout", DOUT, 0);
        check("rst_vout", VOUT, 0);
        check("rst_level", LEVEL, 0);
        check("rst_full", FULL, 0);
        check("rst_ovf", OVF, 0);
        RST_n = 1'b1;
        step();

        // Pass-through with the consumer always ready
        for (int i = 1; i <= 20; i++) begin
            VIN = 1'b1;
            DIN = 12'(i);
            RDY = 1'b1;
            step();
            check("t1_dout", DOUT, i);
            check("t1_vout", VOUT, 1);
            check("t1_level", LEVEL, 1);
        end
        VIN = 1'b0;
        step();
        check("t1_end_vout", VOUT, 0);
        check("t1_end_level", LEVEL, 0);
        check("t1_end_ovf", OVF, 0);
        RDY = 1'b0;

        // Stall to full, hold, then drain in order
        vals = {12'h7FF, 12'h800, 12'hFFF, 12'h000, 12'h555, 12'hAAA, 12'h001, 12'hFFE};
        fill("t2_fill", vals);
        check("t2_full", FULL, 1);
        check("t2_level", LEVEL, 8);
        step();
        check("t2_hold_dout", DOUT, 12'h7FF);
        check("t2_hold_vout", VOUT, 1);
        drain("t2_drain", vals);
        check("t2_ovf", OVF, 0);

        // Push and pop together while full
        vals = {};
        for (int i = 0; i < 8; i++) vals.push_back(12'h101 + 12'(i));
        fill("t4_fill", vals);
        RDY = 1'b1;
        VIN = 1'b1;
        DIN = 12'h3C3;
        step();
        VIN = 1'b0;
        RDY = 1'b0;
        check("t4_level", LEVEL, 8);
        check("t4_full", FULL, 1);
        check("t4_ovf", OVF, 0);
        exp_q = {};
        for (int i = 1; i < 8; i++) exp_q.push_back(12'h101 + 12'(i));
        exp_q.push_back(12'h3C3);
        drain("t4_drain", exp_q);

        // Overflow while stalled: sample dropped, OVF sticky
        vals = {};
        for (int i = 0; i < 8; i++) vals.push_back(12'h200 + 12'(i));
        fill("t3_fill", vals);
        VIN = 1'b1;
        DIN = 12'h123;
        step();
        VIN = 1'b0;
        check("t3_ovf", OVF, 1);
        check("t3_level", LEVEL, 8);
        check("t3_dout", DOUT, 12'h200);
        drain("t3_drain", vals);
        check("t3_ovf_sticky", OVF, 1);

        // CLR beats a simultaneous push and pop
        vals = {12'h301, 12'h302, 12'h303, 12'h304, 12'h305};
        fill("t5_fill", vals);
        check("t5_pre_level", LEVEL, 5);
        check("t5_pre_ovf", OVF, 1);
        CLR = 1'b1;
        VIN = 1'b1;
        DIN = 12'h321;
        RDY = 1'b1;
        step();
        CLR = 1'b0;
        VIN = 1'b0;
        check("t5_clr_level", LEVEL, 0);
        check("t5_clr_vout", VOUT, 0);
        check("t5_clr_dout", DOUT, 0);
        check("t5_clr_ovf", OVF, 0);
        check("t5_clr_full", FULL, 0);
        step();
        check("t5_after_vout", VOUT, 0);
        check("t5_after_level", LEVEL, 0);
        RDY = 1'b0;

        // Asynchronous reset in the middle of a drain
        vals = {};
        for (int i = 0; i < 8; i++) vals.push_back(12'h400 + 12'(i));
        fill("t5r_fill", vals);
        VIN = 1'b1;
        DIN = 12'h0EE;
        step();
        VIN = 1'b0;
        check("t5r_ovf", OVF, 1);
        RDY = 1'b1;
        step();
        check("t5r_dout", DOUT, 12'h401);
        check("t5r_level", LEVEL, 7);
        #2;
        RST_n = 1'b0;
        #1;
        check("t5r_async_dout", DOUT, 0);
        check("t5r_async_vout", VOUT, 0);
        check("t5r_async_level", LEVEL, 0);
        check("t5r_async_full", FULL, 0);
        check("t5r_async_ovf", OVF, 0);
        @(negedge CLK);
        RST_n = 1'b1;
        step();
        check("t5r_rel_vout", VOUT, 0);
        check("t5r_rel_dout", DOUT, 0);
        check("t5r_rel_level", LEVEL, 0);
        RDY = 1'b0;

        // Random traffic against a queue model
        mq     = {};
        ovf_m  = 1'b0;
        pushes = 0;
        for (int cyc = 0; cyc < 2000 && pushes < 100; cyc++) begin
            check("t6_level", LEVEL, mq.size());
            check("t6_vout", VOUT, (mq.size() != 0) ? 1 : 0);
            check("t6_dout", DOUT, (mq.size() != 0) ? mq[0] : 12'h000);
            check("t6_ovf", OVF, ovf_m);
            r_vin  = ($urandom_range(0, 3) != 0);
            r_rdy  = ($urandom_range(0, 1) != 0);
            r_din  = 12'($urandom_range(0, 4095));
            m_full = (mq.size() == 8);
            m_pop  = (mq.size() != 0) && r_rdy;
            m_push = r_vin && (!m_full || m_pop);
            if (r_vin && m_full && !m_pop) ovf_m = 1'b1;
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(r_din);
            if (r_vin) pushes++;
            VIN = r_vin;
            RDY = r_rdy;
            DIN = r_din;
            step();
        end
        VIN = 1'b0;
        RDY = 1'b0;
        check("t6_end_level", LEVEL, mq.size());
        check("t6_end_ovf", OVF, ovf_m);
        vals = mq;
        drain("t6_drain", vals);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
